// File: rtl/imem_loader.sv
// imem_loader: packs a boot byte stream into 32-bit little-endian
// instruction words and issues one instruction-memory write per word,
// holding the core in reset for the duration of the load.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_ADR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;       // word counter / address of the word being assembled
    logic [ADDR_W:0]   r_len;        // number of words in this load
    logic [1:0]        r_byte_idx;   // lane the next byte lands in
    logic [23:0]       r_word;       // lanes 0..2; lane 3 arrives with the completing byte
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_err;

    logic              w_len_ok;
    logic              w_xfer;
    logic              w_last_word;
    logic              w_accept;

    // Start is only legal for 1..DEPTH words; anything else raises err.
    assign w_len_ok    = (load_len != '0) && (load_len <= LP_DEPTH);
    assign w_xfer      = (r_state == S_RECV) && byte_valid;
    assign w_last_word = ({1'b0, r_addr} == (r_len - LP_LEN_ONE));
    assign w_accept    = (r_state == S_IDLE) && start && w_len_ok;

    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign err     = r_err;

    // State register; async reset drops straight to IDLE so wr_en falls immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs; abort overrides everything.
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
                if (w_xfer && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en    = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                w_next   = w_last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // Byte packing, word counter and the registered write port / err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && start && !abort && !w_len_ok;
            if (abort) begin
                // Partial word is dropped; the write port keeps its last written value.
                r_byte_idx <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_len      <= load_len;
                            r_addr     <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                    S_RECV: begin
                        if (w_xfer) begin
                            case (r_byte_idx)
                                2'd0: r_word[7:0]   <= byte_data;
                                2'd1: r_word[15:8]  <= byte_data;
                                2'd2: r_word[23:16] <= byte_data;
                                default: begin
                                    // Completing byte: present the full word during WRITE.
                                    r_wr_data <= {byte_data, r_word};
                                    r_wr_addr <= r_addr;
                                end
                            endcase
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                    S_WRITE: begin
                        r_byte_idx <= '0;
                        if (!w_last_word) begin
                            r_addr <= r_addr + LP_ADR_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed loads with a write scoreboard.
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Expected writes: {addr, data}
    logic [36:0] exp_q[$];

    logic [7:0] t1b [8] = '{8'h33, 8'h00, 8'h30, 8'h00, 8'hB3, 8'h08, 8'h10, 8'h00};

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write and tracks byte transfers.
    int          m_bidx = 0;
    bit          m_exp_wr = 1'b0;
    int          cyc = 0;
    int          last_wr_cyc = -10;
    logic [36:0] ent;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_bidx   = 0;
            m_exp_wr = 1'b0;
        end else begin
            if (wr_en || m_exp_wr)
                check("wr_en_timing", 32'(wr_en), 32'(m_exp_wr));
            if (wr_en) begin
                check("ready_low_in_write", 32'(byte_ready), 0);
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%08h, no write expected", wr_addr, wr_data);
                end else begin
                    ent = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(ent[36:32]));
                    check("wr_data", wr_data, ent[31:0]);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_write", cyc, last_wr_cyc + 1);
            end
            if (err) err_cnt++;
            m_exp_wr = 1'b0;
            if (abort) begin
                m_bidx = 0;
            end else if (byte_valid && byte_ready) begin
                if (m_bidx == 3) begin
                    m_bidx   = 0;
                    m_exp_wr = 1'b1;
                end else begin
                    m_bidx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 0);
        check({tag, "_wr_en"},      32'(wr_en), 0);
        check({tag, "_cpu_hold"},   32'(cpu_hold), 0);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_done"},       32'(done), 0);
        check({tag, "_err"},        32'(err), 0);
        check({tag, "_wr_addr"},    32'(wr_addr), 0);
        check({tag, "_wr_data"},    wr_data, 0);
    endtask

    task automatic do_start(input logic [ADDR_W:0] len);
        start    = 1'b1;
        load_len = len;
        step();
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            step();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: byte_ready=0 after %0d cycles, expected 1", n);
        end else begin
            step();
        end
    endtask

    task automatic send_word(input logic [4:0] a, input logic [31:0] w, input bit gap);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) begin
                byte_valid = 1'b0;
                step();
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        byte_valid = 1'b0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("done_seen", 32'(done), 1);
        check("hold_during_done", 32'(cpu_hold), 1);
        step();
        check("done_one_cycle", 32'(done), 0);
        check("hold_released", 32'(cpu_hold), 0);
        check("busy_released", 32'(busy), 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // Two words back-to-back
        do_start(6'd2);
        check("t1_hold_after_start", 32'(cpu_hold), 1);
        check("t1_busy_after_start", 32'(busy), 1);
        exp_q.push_back({5'd0, 32'h00300033});
        exp_q.push_back({5'd1, 32'h001008B3});
        foreach (t1b[i]) send_byte(t1b[i]);
        byte_valid = 1'b0;
        check("t1_wr_en_last", 32'(wr_en), 1);
        step();
        check("t1_done", 32'(done), 1);
        check("t1_hold_at_done", 32'(cpu_hold), 1);
        step();
        check("t1_done_cleared", 32'(done), 0);
        check("t1_hold_cleared", 32'(cpu_hold), 0);
        check("t1_busy_cleared", 32'(busy), 0);
        check("t1_done_cnt", 32'(done_cnt), 1);

        // One word, byte_valid toggling
        do_start(6'd1);
        send_word(5'd0, 32'hDEADBEEF, 1'b1);
        wait_done();
        check("t2_done_cnt", 32'(done_cnt), 2);

        // Illegal lengths
        do_start(6'd0);
        check("t3_err_len0", 32'(err), 1);
        check("t3_busy_len0", 32'(busy), 0);
        step();
        check("t3_err_pulse_len0", 32'(err), 0);
        do_start(6'd33);
        check("t3_err_len33", 32'(err), 1);
        check("t3_busy_len33", 32'(busy), 0);
        step();
        check("t3_err_pulse_len33", 32'(err), 0);
        check("t3_err_cnt", 32'(err_cnt), 2);

        // Full memory
        do_start(6'd32);
        for (int w = 0; w < 32; w++) send_word(5'(w), $urandom, 1'b0);
        wait_done();
        check("t4_done_cnt", 32'(done_cnt), 3);
        check("t4_queue_empty", 32'(exp_q.size()), 0);

        // Abort after six bytes of a three-word load
        do_start(6'd3);
        send_word(5'd0, 32'h11223344, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        byte_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_hold_after_abort", 32'(cpu_hold), 0);
        check("t5_busy_after_abort", 32'(busy), 0);
        repeat (5) step();
        check("t5_no_done", 32'(done_cnt), 3);
        do_start(6'd1);
        send_word(5'd0, 32'hA5A55A5A, 1'b1);
        wait_done();
        check("t5_reload_done_cnt", 32'(done_cnt), 4);

        // Start ignored during RECV, then reset mid-word
        do_start(6'd2);
        exp_q.push_back({5'd0, 32'h04030201});
        send_byte(8'h01);
        send_byte(8'h02);
        byte_valid = 1'b0;
        start    = 1'b1;
        load_len = 6'd5;
        step();
        start = 1'b0;
        check("t6_busy_restart_ignored", 32'(busy), 1);
        check("t6_no_err_restart", 32'(err), 0);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async_reset");
        step();
        rst_n = 1'b1;
        step();
        do_start(6'd1);
        send_word(5'd0, 32'h0BADF00D, 1'b1);
        wait_done();
        check("t6_done_cnt", 32'(done_cnt), 5);

        // Reset while the write strobe is up
        do_start(6'd1);
        send_word(5'd0, 32'hCAFEBABE, 1'b0);
        byte_valid = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        check("t7_wr_en_drops", 32'(wr_en), 0);
        check("t7_hold_drops", 32'(cpu_hold), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("t7_no_done", 32'(done_cnt), 5);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
